// File: rtl/string_edit_ctrl.sv
// Line-edit controller: keeps a DEPTH-char string with a cursor, applies key events,
// shifts the buffer one entry per cycle on mid-string edits and streams the line out on DOWN.
module string_edit_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_arst_n,
    input  logic          i_en,
    input  logic          i_type,
    input  logic [7:0]    i_asciiex,
    output logic          o_ready,
    output logic          o_drop,
    output logic [7:0]    o_cur_char,
    output logic [AW:0]   o_len,
    output logic [AW:0]   o_cursor,
    output logic          o_full,
    output logic          o_empty,
    output logic [7:0]    o_out_data,
    output logic          o_out_valid,
    output logic          o_out_last,
    input  logic          i_out_ready
);

    // Output stream: o_out_data/o_out_last are held while o_out_valid && !i_out_ready;
    // a beat transfers on any rising edge with o_out_valid && i_out_ready.
    typedef enum logic [1:0] {IDLE, SHIFT_R, SHIFT_L, FLUSH} state_t;

    localparam logic [7:0]  C_RIGHT = 8'h01;
    localparam logic [7:0]  C_DOWN  = 8'h02;
    localparam logic [7:0]  C_LEFT  = 8'h03;
    localparam logic [7:0]  C_BKSP  = 8'h08;
    localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t      state;
    logic [AW:0] idx;
    logic [7:0]  pend_ch;
    logic [7:0]  mem [DEPTH];

    logic        accept, ev_char, ev_ctrl;
    logic [AW:0] cur_p1, cur_m1, len_p1, len_m1, idx_p1, idx_m1;

    assign accept  = i_en & o_ready;
    assign ev_char = accept & ~i_type;
    assign ev_ctrl = accept & i_type;
    assign cur_p1  = o_cursor + ONE;
    assign cur_m1  = o_cursor - ONE;
    assign len_p1  = o_len + ONE;
    assign len_m1  = o_len - ONE;
    assign idx_p1  = idx + ONE;
    assign idx_m1  = idx - ONE;

    // Buffer storage has no reset; o_len masks stale contents.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (ev_char && o_len != MAX_LEN && o_cursor == o_len)
                    mem[o_cursor[AW-1:0]] <= i_asciiex;
            end
            SHIFT_R: begin
                if (idx == o_cursor) mem[o_cursor[AW-1:0]] <= pend_ch;
                else                 mem[idx[AW-1:0]]      <= mem[idx_m1[AW-1:0]];
            end
            SHIFT_L: begin
                if (idx_p1 < o_len) mem[idx[AW-1:0]] <= mem[idx_p1[AW-1:0]];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state       <= IDLE;
            idx         <= '0;
            pend_ch     <= '0;
            o_ready     <= 1'b1;
            o_drop      <= 1'b0;
            o_cur_char  <= '0;
            o_len       <= '0;
            o_cursor    <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_out_data  <= '0;
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
        end else begin
            o_drop <= i_en & ~o_ready;
            case (state)
                IDLE: begin
                    if (ev_char) begin
                        if (o_len == MAX_LEN) begin
                            o_drop <= 1'b1;
                        end else if (o_cursor == o_len) begin
                            o_len      <= len_p1;
                            o_cursor   <= cur_p1;
                            o_cur_char <= '0;
                            o_empty    <= 1'b0;
                            o_full     <= (len_p1 == MAX_LEN);
                        end else begin
                            pend_ch <= i_asciiex;
                            idx     <= o_len;
                            state   <= SHIFT_R;
                            o_ready <= 1'b0;
                        end
                    end else if (ev_ctrl) begin
                        case (i_asciiex)
                            C_RIGHT: begin
                                if (o_cursor < o_len) begin
                                    o_cursor   <= cur_p1;
                                    o_cur_char <= (cur_p1 < o_len) ? mem[cur_p1[AW-1:0]] : 8'h00;
                                end
                            end
                            C_LEFT: begin
                                if (o_cursor != '0) begin
                                    o_cursor   <= cur_m1;
                                    o_cur_char <= mem[cur_m1[AW-1:0]];
                                end
                            end
                            C_BKSP: begin
                                if (o_cursor != '0) begin
                                    if (o_cursor == o_len) begin
                                        o_len      <= len_m1;
                                        o_cursor   <= cur_m1;
                                        o_cur_char <= '0;
                                        o_full     <= 1'b0;
                                        o_empty    <= (len_m1 == '0);
                                    end else begin
                                        idx     <= cur_m1;
                                        state   <= SHIFT_L;
                                        o_ready <= 1'b0;
                                    end
                                end
                            end
                            C_DOWN: begin
                                if (o_len != '0) begin
                                    idx         <= '0;
                                    state       <= FLUSH;
                                    o_ready     <= 1'b0;
                                    o_out_valid <= 1'b1;
                                    o_out_data  <= mem[0];
                                    o_out_last  <= (o_len == ONE);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                SHIFT_R: begin
                    // The slot after the cursor already holds the old cursor char here.
                    if (idx == o_cursor) begin
                        o_len      <= len_p1;
                        o_cursor   <= cur_p1;
                        o_cur_char <= mem[cur_p1[AW-1:0]];
                        o_empty    <= 1'b0;
                        o_full     <= (len_p1 == MAX_LEN);
                        state      <= IDLE;
                        o_ready    <= 1'b1;
                    end else begin
                        idx <= idx_m1;
                    end
                end
                SHIFT_L: begin
                    if (idx_p1 >= o_len) begin
                        o_len      <= len_m1;
                        o_cursor   <= cur_m1;
                        o_cur_char <= mem[cur_m1[AW-1:0]];
                        o_full     <= 1'b0;
                        o_empty    <= 1'b0;
                        state      <= IDLE;
                        o_ready    <= 1'b1;
                    end else begin
                        idx <= idx_p1;
                    end
                end
                FLUSH: begin
                    if (i_out_ready) begin
                        if (o_out_last) begin
                            o_out_valid <= 1'b0;
                            o_out_last  <= 1'b0;
                            o_len       <= '0;
                            o_cursor    <= '0;
                            o_cur_char  <= '0;
                            o_full      <= 1'b0;
                            o_empty     <= 1'b1;
                            state       <= IDLE;
                            o_ready     <= 1'b1;
                        end else begin
                            idx        <= idx_p1;
                            o_out_data <= mem[idx_p1[AW-1:0]];
                            o_out_last <= (idx_p1 == len_m1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_string_edit_ctrl.sv
// Bench for string_edit_ctrl: directed scenarios plus random key events checked
// against a queue-based model of the edited line.
module tb_string_edit_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          i_arst_n = 1'b0;
    logic          i_en = 1'b0;
    logic          i_type = 1'b0;
    logic [7:0]    i_asciiex = 8'h00;
    logic          i_out_ready = 1'b0;
    logic          o_ready, o_drop, o_full, o_empty, o_out_valid, o_out_last;
    logic [7:0]    o_cur_char, o_out_data;
    logic [AW:0]   o_len, o_cursor;

    string_edit_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .i_arst_n(i_arst_n), .i_en(i_en), .i_type(i_type), .i_asciiex(i_asciiex),
        .o_ready(o_ready), .o_drop(o_drop), .o_cur_char(o_cur_char), .o_len(o_len),
        .o_cursor(o_cursor), .o_full(o_full), .o_empty(o_empty), .o_out_data(o_out_data),
        .o_out_valid(o_out_valid), .o_out_last(o_out_last), .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         m_cursor = 0;
    int         last_busy;
    logic       last_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] cc;
        cc = (m_cursor < exp_q.size()) ? exp_q[m_cursor] : 8'h00;
        chk({tag, ":len"},    32'(o_len),      32'(exp_q.size()));
        chk({tag, ":cursor"}, 32'(o_cursor),   32'(m_cursor));
        chk({tag, ":cur"},    32'(o_cur_char), 32'(cc));
        chk({tag, ":full"},   32'(o_full),     32'(exp_q.size() == DEPTH));
        chk({tag, ":empty"},  32'(o_empty),    32'(exp_q.size() == 0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ":ready"}, 32'(o_ready),     1);
        chk({tag, ":drop"},  32'(o_drop),      0);
        chk({tag, ":cur"},   32'(o_cur_char),  0);
        chk({tag, ":len"},   32'(o_len),       0);
        chk({tag, ":cur_p"}, 32'(o_cursor),    0);
        chk({tag, ":full"},  32'(o_full),      0);
        chk({tag, ":empty"}, 32'(o_empty),     1);
        chk({tag, ":valid"}, 32'(o_out_valid), 0);
        chk({tag, ":last"},  32'(o_out_last),  0);
    endtask

    // Line semantics: insert before the cursor, delete the char left of the cursor.
    task automatic model_step(input logic t, input logic [7:0] code, output int eb, output logic ed);
        int len;
        len = exp_q.size();
        eb = 0;
        ed = 1'b0;
        if (!t) begin
            if (len == DEPTH) ed = 1'b1;
            else begin
                eb = (m_cursor == len) ? 0 : len - m_cursor + 1;
                exp_q.insert(m_cursor, code);
                m_cursor++;
            end
        end else begin
            case (code)
                8'h01: if (m_cursor < len) m_cursor++;
                8'h03: if (m_cursor > 0) m_cursor--;
                8'h08: if (m_cursor > 0) begin
                    eb = (m_cursor == len) ? 0 : len - m_cursor + 1;
                    exp_q.delete(m_cursor - 1);
                    m_cursor--;
                end
                default: ;
            endcase
        end
    endtask

    task automatic send(input logic t, input logic [7:0] code, input bit wait_idle);
        int w;
        w = 0;
        while (!o_ready && w < 200) begin @(negedge clk); w++; end
        if (!o_ready) chk("ready_timeout", 32'(o_ready), 1);
        i_en = 1'b1; i_type = t; i_asciiex = code;
        @(negedge clk);
        i_en = 1'b0;
        last_drop = o_drop;
        last_busy = 0;
        if (wait_idle)
            while (!o_ready && last_busy < 200) begin last_busy++; @(negedge clk); end
    endtask

    task automatic key(input logic t, input logic [7:0] code, input string tag);
        int   eb;
        logic ed;
        model_step(t, code, eb, ed);
        send(t, code, 1'b1);
        chk({tag, ":busy"}, 32'(last_busy), 32'(eb));
        chk({tag, ":dropq"}, 32'(last_drop), 32'(ed));
        check_model(tag);
        @(negedge clk);
    endtask

    task automatic down(input string tag, input logic [31:0] pat, input bit use_rand);
        logic [7:0] line[$];
        int k, cyc;
        logic rdy;
        if (exp_q.size() == 0) key(1'b1, 8'h02, tag);
        else begin
            line = exp_q;
            send(1'b1, 8'h02, 1'b0);
            chk({tag, ":busy_flush"}, 32'(o_ready), 0);
            k = 0; cyc = 0;
            while (k < line.size() && cyc < 400) begin
                rdy = use_rand ? 1'($urandom_range(0, 1)) : pat[cyc % 32];
                i_out_ready = rdy;
                chk({tag, ":valid"}, 32'(o_out_valid), 1);
                if (o_out_valid) begin
                    chk({tag, ":data"}, 32'(o_out_data), 32'(line[k]));
                    chk({tag, ":last"}, 32'(o_out_last), 32'(k == line.size() - 1));
                    if (rdy) k++;
                end
                cyc++;
                @(negedge clk);
            end
            i_out_ready = 1'b0;
            chk({tag, ":beats"}, 32'(k), 32'(line.size()));
            exp_q.delete();
            m_cursor = 0;
            chk({tag, ":valid_end"}, 32'(o_out_valid), 0);
            chk({tag, ":ready_end"}, 32'(o_ready), 1);
            check_model(tag);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        i_arst_n = 1'b0;
        #1;
        chk_reset(tag);
        exp_q.delete();
        m_cursor = 0;
        @(negedge clk);
        i_arst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int eb;
        logic ed;
        // Power-on reset
        i_arst_n = 1'b0;
        #12;
        chk_reset("por");
        @(negedge clk);
        i_arst_n = 1'b1;
        @(negedge clk);
        chk_reset("por_rel");

        // Append, cursor moves, insert and delete mid-string
        key(1'b0, 8'h41, "t1a"); key(1'b0, 8'h42, "t1b"); key(1'b0, 8'h43, "t1c");
        key(1'b1, 8'h03, "t2l"); key(1'b1, 8'h03, "t2l");
        key(1'b0, 8'h58, "t2ins");
        chk("t2_curchar", 32'(o_cur_char), 32'h42);
        key(1'b1, 8'h08, "t3bs");
        chk("t3_curchar", 32'(o_cur_char), 32'h42);
        key(1'b1, 8'h03, "t3l");
        key(1'b1, 8'h08, "t3bs0");
        key(1'b1, 8'h03, "t3l0");
        key(1'b1, 8'h7f, "t3unk");

        // Fill to capacity, overflow drop
        do_reset("t4rst");
        for (int i = 0; i < DEPTH; i++) key(1'b0, 8'($urandom_range(8'h21, 8'h7e)), "t4fill");
        key(1'b0, 8'h5a, "t4ovf");
        chk("t4_full", 32'(o_full), 1);
        key(1'b1, 8'h01, "t4r_sat");
        key(1'b1, 8'h03, "t4l");
        key(1'b1, 8'h08, "t4bs");

        // Event offered during SHIFT_R is dropped without disturbing the insert
        do_reset("t4b_rst");
        for (int i = 0; i < 5; i++) key(1'b0, 8'(8'h61 + i), "t4b_fill");
        for (int i = 0; i < 3; i++) key(1'b1, 8'h03, "t4b_l");
        model_step(1'b0, 8'h51, eb, ed);
        send(1'b0, 8'h51, 1'b0);
        i_en = 1'b1; i_type = 1'b0; i_asciiex = 8'h52;
        @(negedge clk);
        i_en = 1'b0;
        chk("t4b_busydrop", 32'(o_drop), 1);
        last_busy = 0;
        while (!o_ready && last_busy < 200) begin last_busy++; @(negedge clk); end
        chk("t4b_busy", 32'(last_busy + 1), 32'(eb));
        check_model("t4b");
        @(negedge clk);

        // Flush with back-pressure 1,0,1,1
        do_reset("t5rst");
        key(1'b0, 8'h41, "t5a"); key(1'b0, 8'h42, "t5b"); key(1'b0, 8'h43, "t5c");
        down("t5", 32'hffff_fffd, 1'b0);
        down("t5empty", 32'hffff_ffff, 1'b0);

        // Reset mid-SHIFT_R and mid-FLUSH
        for (int i = 0; i < 8; i++) key(1'b0, 8'(8'h30 + i), "t6fill");
        for (int i = 0; i < 7; i++) key(1'b1, 8'h03, "t6l");
        send(1'b0, 8'h59, 1'b0);
        @(negedge clk);
        do_reset("t6shift");
        key(1'b0, 8'h5a, "t6z");
        key(1'b0, 8'h41, "t6a"); key(1'b0, 8'h42, "t6b");
        i_out_ready = 1'b0;
        send(1'b1, 8'h02, 1'b0);
        chk("t6_fvalid", 32'(o_out_valid), 1);
        @(negedge clk);
        do_reset("t6flush");
        key(1'b0, 8'h5a, "t6z2");

        // Random edit sessions
        for (int n = 0; n < 250; n++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r < 5)       key(1'b0, 8'($urandom_range(8'h20, 8'h7e)), "rnd_ch");
            else if (r == 5) key(1'b1, 8'h03, "rnd_l");
            else if (r == 6) key(1'b1, 8'h01, "rnd_r");
            else if (r < 9)  key(1'b1, 8'h08, "rnd_bs");
            else if (r == 9) key(1'b1, 8'($urandom_range(8'h09, 8'hff)), "rnd_unk");
            else if ($urandom_range(0, 3) == 0) down("rnd_dn", 32'h0, 1'b1);
            else key(1'b0, 8'($urandom_range(8'h20, 8'h7e)), "rnd_ch2");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
